image_capture: RTL and testbench

IMAGE_CAPTURE -- requirements
Module: image_capture

---
 rtl/image_capture.sv | 166 ++++++++++++++++
 tb/tb_image_capture.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/image_capture.sv
// Captures one RGB frame, two pixels per HSYNC cycle, into a byte store laid out
// bottom-up (BMP order), with a one-cycle-latency readback port.
module image_capture #(
    parameter int WIDTH       = 10,
    parameter int HEIGHT      = 5,
    parameter int FRAME_BYTES = WIDTH * HEIGHT * 3
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        VSYNC,
    input  logic        HSYNC,
    input  logic [7:0]  DATA_R0,
    input  logic [7:0]  DATA_G0,
    input  logic [7:0]  DATA_B0,
    input  logic [7:0]  DATA_R1,
    input  logic [7:0]  DATA_G1,
    input  logic [7:0]  DATA_B1,
    input  logic        rd_en,
    input  logic [15:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        frame_done,
    output logic        busy,
    output logic        overflow
);

    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [RW-1:0] LAST_ROW  = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(WIDTH - 2);
    localparam logic [15:0]   ROW_BYTES = 16'(WIDTH * 3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          frame_done_q, frame_done_d;
    logic          overflow_q, overflow_d;
    logic          rd_valid_q;
    logic [7:0]    rd_data_q;

    logic [7:0]    mem [FRAME_BYTES];

    logic          captureOpen;
    logic          capture;
    logic          lastPair;
    logic [15:0]   baseAddr;
    logic [15:0]   wrAddr [6];
    logic          wrOk   [6];
    logic [7:0]    wrByte [6];
    logic          rdInRange;

    assign captureOpen = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    // VSYNC outranks HSYNC, so a pair arriving with VSYNC is dropped.
    assign capture     = captureOpen && HSYNC && !VSYNC;
    assign lastPair    = (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign baseAddr    = ROW_BYTES * (16'(LAST_ROW) - 16'(row_q)) + 16'(col_q) * 16'd3;
    assign rdInRange   = {16'd0, rd_addr} < 32'(FRAME_BYTES);

    assign wrByte[0] = DATA_R0;
    assign wrByte[1] = DATA_G0;
    assign wrByte[2] = DATA_B0;
    assign wrByte[3] = DATA_R1;
    assign wrByte[4] = DATA_G1;
    assign wrByte[5] = DATA_B1;

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            wrAddr[i] = baseAddr + 16'(i);
            wrOk[i]   = {16'd0, wrAddr[i]} < 32'(FRAME_BYTES);
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (HSYNC) overflow_d = 1'b1;
                if (VSYNC) begin
                    state_d = ST_ARMED;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_ARMED, ST_CAPTURE: begin
                if (VSYNC) begin
                    state_d = ST_ARMED;
                    row_d   = '0;
                    col_d   = '0;
                end else if (HSYNC) begin
                    if (lastPair) begin
                        state_d      = ST_DONE;
                        row_d        = '0;
                        col_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = ST_CAPTURE;
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + CW'(2);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // The frame store has no reset so a captured image survives HRESET.
    always_ff @(posedge HCLK) begin
        if (capture) begin
            if (wrOk[0]) mem[wrAddr[0][AW-1:0]] <= wrByte[0];
            if (wrOk[1]) mem[wrAddr[1][AW-1:0]] <= wrByte[1];
            if (wrOk[2]) mem[wrAddr[2][AW-1:0]] <= wrByte[2];
            if (wrOk[3]) mem[wrAddr[3][AW-1:0]] <= wrByte[3];
            if (wrOk[4]) mem[wrAddr[4][AW-1:0]] <= wrByte[4];
            if (wrOk[5]) mem[wrAddr[5][AW-1:0]] <= wrByte[5];
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= rdInRange ? mem[rd_addr[AW-1:0]] : 8'h00;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = captureOpen;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_image_capture.sv
// Bench for image_capture: drives whole frames, mirrors the byte store in a
// reference array and checks readbacks through an expected-data queue.
module tb_image_capture;

    localparam int W  = 10;
    localparam int H  = 5;
    localparam int FB = W * H * 3;
    localparam int PAIRS = W * H / 2;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b0;
    logic        VSYNC = 1'b0;
    logic        HSYNC = 1'b0;
    logic [7:0]  DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
    logic [7:0]  DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
    logic        rd_en = 1'b0;
    logic [15:0] rd_addr = '0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        frame_done;
    logic        busy;
    logic        overflow;

    image_capture #(.WIDTH(W), .HEIGHT(H)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .VSYNC      (VSYNC),
        .HSYNC      (HSYNC),
        .DATA_R0    (DATA_R0),
        .DATA_G0    (DATA_G0),
        .DATA_B0    (DATA_B0),
        .DATA_R1    (DATA_R1),
        .DATA_G1    (DATA_G1),
        .DATA_B1    (DATA_B1),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .frame_done (frame_done),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  expData;
    } rdVec_t;

    rdVec_t     readVecs [7];
    int         checks = 0;
    int         failures = 0;
    int         fdCount = 0;
    logic       sFd, sBusy, sOvf;
    logic [7:0] refMem [FB];
    logic [7:0] src [FB];
    logic [7:0] expQ [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Samples what the previous edge produced, then drives the next cycle.
    task automatic applyStimulus(input logic v, input logic h, input logic [47:0] pix,
                                 input logic re, input logic [15:0] ra, input logic [7:0] expRd);
        logic [7:0] e;
        @(negedge HCLK);
        sFd   = frame_done;
        sBusy = busy;
        sOvf  = overflow;
        if (frame_done) fdCount++;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("rd_valid", 32'(rd_valid), 32'd1);
            checkOutput("rd_data", 32'(rd_data), 32'(e));
        end else begin
            checkOutput("rd_valid_idle", 32'(rd_valid), 32'd0);
        end
        VSYNC = v;
        HSYNC = h;
        {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1} = pix;
        rd_en   = re;
        rd_addr = ra;
        if (re) expQ.push_back(expRd);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic doReset();
        HRESET = 1'b1;
        VSYNC = 1'b0;
        HSYNC = 1'b0;
        rd_en = 1'b0;
        expQ.delete();
        #1;
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    function automatic logic [47:0] pixFor(input int pat, input int k, input int row, input int col);
        int b;
        b = W * 3 * (H - 1 - row) + 3 * col;
        case (pat)
            0:       return {{3{8'(2 * k)}}, {3{8'(2 * k + 1)}}};
            1:       return {src[b], src[b+1], src[b+2], src[b+3], src[b+4], src[b+5]};
            2:       return {6{8'(100 + k)}};
            default: return {6{8'(128 + k)}};
        endcase
    endfunction

    // Updates the reference store for a pair, optionally reading the same cycle.
    task automatic drivePair(input int row, input int col, input logic [47:0] pix,
                             input logic re, input logic [15:0] ra);
        logic [7:0] e;
        int b;
        e = re ? refMem[ra] : 8'h00;
        b = W * 3 * (H - 1 - row) + 3 * col;
        for (int i = 0; i < 6; i++) refMem[b + i] = pix[47 - 8 * i -: 8];
        applyStimulus(1'b0, 1'b1, pix, re, ra, e);
    endtask

    task automatic sendFrame(input int pat, input int gapPair, input int gapRow, input bit rdSame);
        int row, col;
        fdCount = 0;
        for (int k = 0; k < PAIRS; k++) begin
            row = k / (W / 2);
            col = 2 * (k % (W / 2));
            if (k == PAIRS - 1) checkOutput("frame_done_early", 32'(fdCount), 32'd0);
            drivePair(row, col, pixFor(pat, k, row, col), rdSame && (k == 0), 16'(W * 3 * (H - 1)));
            if (k == 2) checkOutput("busy_capture", 32'(sBusy), 32'd1);
            if (k != PAIRS - 1) begin
                repeat (gapPair) idle();
                if (col == W - 2) repeat (gapRow) idle();
            end
        end
        idle();
        checkOutput("frame_done_edge", 32'(sFd), 32'd1);
        checkOutput("busy_done", 32'(sBusy), 32'd0);
        idle();
        checkOutput("frame_done_single", 32'(sFd), 32'd0);
        repeat (3) idle();
        checkOutput("frame_done_count", 32'(fdCount), 32'd1);
    endtask

    task automatic readAll(input bit useSrc);
        for (int a = 0; a < FB; a++)
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'(a), useSrc ? src[a] : refMem[a]);
        idle();
    endtask

    initial begin
        readVecs[0] = '{16'd120, 8'd0};
        readVecs[1] = '{16'd123, 8'd1};
        readVecs[2] = '{16'd0,   8'd40};
        readVecs[3] = '{16'd3,   8'd41};
        readVecs[4] = '{16'd29,  8'd49};
        readVecs[5] = '{16'd149, 8'd9};
        readVecs[6] = '{16'd200, 8'd0};
        for (int i = 0; i < FB; i++) begin
            refMem[i] = 8'h00;
            src[i]    = 8'($urandom_range(0, 255));
        end

        #2;
        doReset();

        $display("[TB] nominal frame");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
        idle();
        idle();
        checkOutput("busy_armed", 32'(sBusy), 32'd1);
        sendFrame(0, 0, 0, 1'b0);
        checkOutput("overflow_nominal", 32'(sOvf), 32'd0);
        for (int i = 0; i < 7; i++)
            applyStimulus(1'b0, 1'b0, '0, 1'b1, readVecs[i].addr, readVecs[i].expData);
        idle();

        $display("[TB] overflow in done state");
        applyStimulus(1'b0, 1'b1, {6{8'hFF}}, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b1, {6{8'hFF}}, 1'b0, '0, '0);
        idle();
        checkOutput("overflow_set", 32'(sOvf), 32'd1);
        checkOutput("busy_overflow", 32'(sBusy), 32'd0);
        readAll(1'b0);
        checkOutput("overflow_sticky", 32'(sOvf), 32'd1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
        idle();
        checkOutput("overflow_sticky_vsync", 32'(sOvf), 32'd1);
        doReset();

        $display("[TB] round-trip frame");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
        sendFrame(1, 0, 0, 1'b0);
        readAll(1'b1);

        $display("[TB] gapped frame");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
        sendFrame(0, 3, 10, 1'b1);
        readAll(1'b0);

        $display("[TB] aborted frame");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
        fdCount = 0;
        for (int k = 0; k < 7; k++)
            drivePair(k / (W / 2), 2 * (k % (W / 2)), pixFor(2, k, 0, 0), 1'b0, '0);
        applyStimulus(1'b1, 1'b1, {6{8'hEE}}, 1'b0, '0, '0);
        idle();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'd138, 8'd103);
        idle();
        checkOutput("abort_no_done", 32'(fdCount), 32'd0);
        checkOutput("busy_after_abort", 32'(sBusy), 32'd1);
        sendFrame(0, 0, 0, 1'b0);
        checkOutput("abort_no_overflow", 32'(sOvf), 32'd0);
        readAll(1'b0);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
        for (int k = 0; k < 12; k++)
            drivePair(k / (W / 2), 2 * (k % (W / 2)), pixFor(3, k, 0, 0), 1'b0, '0);
        idle();
        doReset();
        applyStimulus(1'b0, 1'b1, {6{8'hFF}}, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b1, {6{8'hFF}}, 1'b0, '0, '0);
        idle();
        checkOutput("overflow_idle", 32'(sOvf), 32'd1);
        checkOutput("busy_after_reset", 32'(sBusy), 32'd0);
        readAll(1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'd200, 8'h00);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
